// File: rtl/bsg_bp_mem_channel_striper.sv
// Stripes upstream memory commands across num_chan_p channels by address and
// merges channel responses back upstream in original command order.

module bsg_bp_mem_channel_striper_checker (
    input logic clk_i,
    input logic reset_i,
    input logic push_i,
    input logic pop_i,
    input logic full_i,
    input logic empty_i
);

    // Order FIFO must never overflow or underflow.
    assert property (@(posedge clk_i) disable iff (reset_i) !(push_i && full_i));
    assert property (@(posedge clk_i) disable iff (reset_i) !(pop_i && empty_i));

endmodule

module bsg_bp_mem_channel_striper #(
    parameter int num_chan_p        = 2,
    parameter int cmd_width_p       = 128,
    parameter int resp_width_p      = 128,
    parameter int addr_width_p      = 40,
    parameter int stripe_lsb_p      = 6,
    parameter int hash_en_p         = 0,
    parameter int max_outstanding_p = 8,
    localparam int lg_chan_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1,
    localparam int ptr_w_lp   = $clog2(max_outstanding_p),
    localparam int cnt_w_lp   = $clog2(max_outstanding_p + 1)
) (
    input  logic                                    clk_i,
    input  logic                                    reset_i,
    input  logic [cmd_width_p-1:0]                  cmd_i,
    input  logic [addr_width_p-1:0]                 cmd_addr_i,
    input  logic                                    cmd_v_i,
    output logic                                    cmd_ready_and_o,
    output logic [num_chan_p-1:0][cmd_width_p-1:0]  cmd_o,
    output logic [num_chan_p-1:0]                   cmd_v_o,
    input  logic [num_chan_p-1:0]                   cmd_ready_and_i,
    input  logic [num_chan_p-1:0][resp_width_p-1:0] resp_i,
    input  logic [num_chan_p-1:0]                   resp_v_i,
    output logic [num_chan_p-1:0]                   resp_ready_and_o,
    output logic [resp_width_p-1:0]                 resp_o,
    output logic                                    resp_v_o,
    input  logic                                    resp_ready_and_i,
    output logic [cnt_w_lp-1:0]                     outstanding_o
);

    logic [lg_chan_lp-1:0] sel_s;
    logic [lg_chan_lp-1:0] head_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  accept_ok_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  addr_unused_s;

    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic [lg_chan_lp-1:0] order_q [max_outstanding_p];

    // Only the stripe field of the address matters; the rest is folded away.
    assign addr_unused_s = ^cmd_addr_i;

    if (num_chan_p == 1) begin : g_single
        assign sel_s = '0;
    end else if (hash_en_p != 0) begin : g_hash
        assign sel_s = cmd_addr_i[stripe_lsb_p +: lg_chan_lp]
                     ^ cmd_addr_i[stripe_lsb_p + lg_chan_lp +: lg_chan_lp];
    end else begin : g_plain
        assign sel_s = cmd_addr_i[stripe_lsb_p +: lg_chan_lp];
    end

    assign full_s        = (count_q == cnt_w_lp'(max_outstanding_p));
    assign empty_s       = (count_q == '0);
    assign head_s        = order_q[rd_ptr_q];
    assign accept_ok_s   = ~full_s & ~reset_i;
    assign push_s        = cmd_v_i & cmd_ready_and_o;
    assign pop_s         = resp_v_o & resp_ready_and_i;
    assign outstanding_o = count_q;

    // Command fan-out: broadcast payload, steer valid to the selected channel.
    always_comb begin
        cmd_o           = '0;
        cmd_v_o         = '0;
        cmd_ready_and_o = cmd_ready_and_i[sel_s] & accept_ok_s;
        for (int c = 0; c < num_chan_p; c++) begin
            cmd_o[c]   = cmd_i;
            cmd_v_o[c] = cmd_v_i & accept_ok_s & (sel_s == lg_chan_lp'(c));
        end
    end

    // Response merge: only the channel at the FIFO head may hand off.
    always_comb begin
        resp_o           = resp_i[head_s];
        resp_v_o         = resp_v_i[head_s] & ~empty_s;
        resp_ready_and_o = '0;
        for (int c = 0; c < num_chan_p; c++) begin
            resp_ready_and_o[c] = resp_ready_and_i & ~empty_s & (head_s == lg_chan_lp'(c));
        end
    end

    // Next-state for pointers and in-flight count.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + ptr_w_lp'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + ptr_w_lp'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + cnt_w_lp'(1'b1);
            2'b01:   count_d = count_q - cnt_w_lp'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Order storage: channel id of each in-flight command.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < max_outstanding_p; i++) begin
                order_q[i] <= '0;
            end
        end else if (push_s) begin
            order_q[wr_ptr_q] <= sel_s;
        end else begin
            order_q[wr_ptr_q] <= order_q[wr_ptr_q];
        end
    end

    bsg_bp_mem_channel_striper_checker u_checker (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .full_i  (full_s),
        .empty_i (empty_s)
    );

endmodule

// File: tb/tb_bsg_bp_mem_channel_striper.sv
// Scoreboard bench: channel models answer commands, a monitor checks ordering,
// handshakes and counts against a queue-based reference.

module tb_bsg_bp_mem_channel_striper;

    localparam int NC = 2;
    localparam int MO = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_i;
    logic [127:0]         cmd_i;
    logic [39:0]          cmd_addr_i;
    logic                 cmd_v_i;
    logic                 cmd_ready_and_o;
    logic [NC-1:0][127:0] cmd_o;
    logic [NC-1:0]        cmd_v_o;
    logic [NC-1:0]        cmd_ready_and_i;
    logic [NC-1:0][127:0] resp_i;
    logic [NC-1:0]        resp_v_i;
    logic [NC-1:0]        resp_ready_and_o;
    logic [127:0]         resp_o;
    logic                 resp_v_o;
    logic                 resp_ready_and_i;
    logic [3:0]           outstanding_o;

    logic [39:0]          h_addr;
    logic                 h_ready_unused;
    logic [3:0][127:0]    h_cmd_o_unused;
    logic [3:0]           h_cmd_v_o;
    logic [3:0]           h_resp_rdy_unused;
    logic [127:0]         h_resp_o_unused;
    logic                 h_resp_v_unused;
    logic [3:0]           h_out_unused;

    bsg_bp_mem_channel_striper u_dut (
        .clk_i(clk), .reset_i(reset_i), .cmd_i(cmd_i), .cmd_addr_i(cmd_addr_i),
        .cmd_v_i(cmd_v_i), .cmd_ready_and_o(cmd_ready_and_o), .cmd_o(cmd_o),
        .cmd_v_o(cmd_v_o), .cmd_ready_and_i(cmd_ready_and_i), .resp_i(resp_i),
        .resp_v_i(resp_v_i), .resp_ready_and_o(resp_ready_and_o), .resp_o(resp_o),
        .resp_v_o(resp_v_o), .resp_ready_and_i(resp_ready_and_i),
        .outstanding_o(outstanding_o)
    );

    bsg_bp_mem_channel_striper #(.num_chan_p(4), .hash_en_p(1)) u_hash (
        .clk_i(clk), .reset_i(reset_i), .cmd_i(128'd0), .cmd_addr_i(h_addr),
        .cmd_v_i(1'b1), .cmd_ready_and_o(h_ready_unused), .cmd_o(h_cmd_o_unused),
        .cmd_v_o(h_cmd_v_o), .cmd_ready_and_i(4'b0000), .resp_i({4{128'd0}}),
        .resp_v_i(4'b0000), .resp_ready_and_o(h_resp_rdy_unused), .resp_o(h_resp_o_unused),
        .resp_v_o(h_resp_v_unused), .resp_ready_and_i(1'b1), .outstanding_o(h_out_unused)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference channel selection: address bit 6 picks one of two channels.
    function automatic int model_sel(input logic [39:0] a);
        return int'((a >> 6) & 40'd1);
    endfunction

    typedef struct { int chan; logic [127:0] data; } exp_t;
    typedef logic [127:0] dq_t [$];
    exp_t exp_q [$];
    int   popped_q [$];
    dq_t  chan_q [NC];

    logic [NC-1:0] resp_en = 2'b00;
    logic          rand_mode = 1'b0;
    int            flush_gen = 0;
    int            flush_seen = 0;
    int            seq = 1;

    // Channel model: capture accepted commands, retire accepted responses.
    always @(negedge clk) begin
        if (flush_gen != flush_seen) begin
            for (int c = 0; c < NC; c++) chan_q[c].delete();
            flush_seen = flush_gen;
        end else if (!reset_i) begin
            for (int c = 0; c < NC; c++) begin
                if (resp_v_i[c] && resp_ready_and_o[c] && chan_q[c].size() > 0)
                    void'(chan_q[c].pop_front());
                if (cmd_v_o[c] && cmd_ready_and_i[c])
                    chan_q[c].push_back(cmd_o[c]);
            end
        end
    end

    // Channel response driver: response payload is command + channel + 1.
    always @(posedge clk) begin
        #2;
        for (int c = 0; c < NC; c++) begin
            if (chan_q[c].size() > 0 && resp_en[c] && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                resp_v_i[c] = 1'b1;
                resp_i[c]   = chan_q[c][0] + 128'(c) + 128'd1;
            end else begin
                resp_v_i[c] = 1'b0;
                resp_i[c]   = {$urandom, $urandom, $urandom, $urandom};
            end
        end
        resp_ready_and_i = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Monitor and scoreboard.
    always @(negedge clk) begin : mon
        int           s;
        int           model_cnt;
        int           head;
        logic         full;
        logic [NC-1:0] exp_v;
        logic [NC-1:0] exp_rr;
        logic          exp_rv;
        exp_t          e;
        if (reset_i) begin
            chk("reset_cmd_ready", 128'(cmd_ready_and_o), 128'd0);
            chk("reset_cmd_v", 128'(cmd_v_o), 128'd0);
            model_cnt = 0;
            exp_q.delete();
        end else begin
            s     = model_sel(cmd_addr_i);
            full  = (model_cnt == MO);
            exp_v = (cmd_v_i && !full) ? NC'(1 << s) : '0;
            chk("outstanding", 128'(outstanding_o), 128'(model_cnt));
            chk("cmd_ready", 128'(cmd_ready_and_o), 128'(cmd_ready_and_i[s] && !full));
            chk("cmd_v_o", 128'(cmd_v_o), 128'(exp_v));
            chk("cmd_o", cmd_o[s], cmd_i);
            if (exp_q.size() > 0) begin
                head   = exp_q[0].chan;
                exp_rv = resp_v_i[head];
                exp_rr = resp_ready_and_i ? NC'(1 << head) : '0;
            end else begin
                exp_rv = 1'b0;
                exp_rr = '0;
            end
            chk("resp_v_o", 128'(resp_v_o), 128'(exp_rv));
            chk("resp_ready", 128'(resp_ready_and_o), 128'(exp_rr));
            if (resp_v_o && resp_ready_and_i) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got %0h expected no response", resp_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_data", resp_o, e.data);
                    popped_q.push_back(e.chan);
                    model_cnt--;
                end
            end
            if (cmd_v_i && cmd_ready_and_o) begin
                exp_q.push_back('{s, cmd_i + 128'(s) + 128'd1});
                model_cnt++;
            end
        end
    end

    task automatic send(input logic [39:0] a, output logic [NC-1:0] vo);
        int   n;
        logic acc;
        cmd_addr_i = a;
        cmd_i      = {32'(seq), $urandom, $urandom, $urandom};
        seq++;
        cmd_v_i    = 1'b1;
        acc = 1'b0;
        n   = 0;
        vo  = '0;
        while (!acc && n < 300) begin
            if (rand_mode) cmd_ready_and_i = NC'($urandom_range(0, 3));
            @(negedge clk);
            acc = cmd_ready_and_o;
            vo  = cmd_v_o;
            n++;
            @(posedge clk); #1;
        end
        cmd_v_i = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got no accept expected accept for addr %0h", a);
        end
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (outstanding_o != 4'd0 && n < 1000);
        if (outstanding_o != 4'd0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d expected 0", outstanding_o);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NC-1:0] vo;
        int            first_pop;
        int            acc_cyc;
        int            n;
        logic [39:0]   haddrs [5];
        reset_i          = 1'b1;
        cmd_v_i          = 1'b1;
        cmd_addr_i       = 40'h0;
        cmd_i            = 128'd0;
        cmd_ready_and_i  = 2'b11;
        resp_v_i         = 2'b00;
        resp_i           = '0;
        resp_ready_and_i = 1'b1;
        h_addr           = 40'h0;
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        cmd_v_i = 1'b0;
        @(negedge clk);
        chk("reset_outstanding", 128'(outstanding_o), 128'd0);
        chk("reset_resp_v", 128'(resp_v_o), 128'd0);
        chk("reset_resp_ready", 128'(resp_ready_and_o), 128'd0);
        @(posedge clk); #1;

        // Striping: 0x000, 0x040, 0x080 -> channels 0, 1, 0.
        send(40'h000, vo); chk("stripe_000", 128'(vo), 128'd1);
        send(40'h040, vo); chk("stripe_040", 128'(vo), 128'd2);
        send(40'h080, vo); chk("stripe_080", 128'(vo), 128'd1);
        @(negedge clk);
        chk("outstanding_3", 128'(outstanding_o), 128'd3);

        // Channel 1 answers first; it must be held off until channel 0 pops.
        popped_q.delete();
        resp_en = 2'b10;
        repeat (4) @(negedge clk);
        chk("ch1_held_ready", 128'(resp_ready_and_o[1]), 128'd0);
        chk("ch1_held_v", 128'(resp_v_o), 128'd0);
        chk("ch1_held_cnt", 128'(outstanding_o), 128'd3);
        resp_en = 2'b11;
        wait_drain();
        chk("order_len", 128'(popped_q.size()), 128'd3);
        if (popped_q.size() == 3) begin
            chk("order_0", 128'(popped_q[0]), 128'd0);
            chk("order_1", 128'(popped_q[1]), 128'd1);
            chk("order_2", 128'(popped_q[2]), 128'd0);
        end

        // Fill to capacity, 9th blocked, accepted the cycle after the first pop.
        resp_en = 2'b00;
        for (int i = 0; i < MO; i++) send(40'($urandom), vo);
        @(negedge clk);
        chk("outstanding_full", 128'(outstanding_o), 128'(MO));
        @(posedge clk); #1;
        cmd_addr_i = 40'($urandom);
        cmd_i      = {32'(seq), $urandom, $urandom, $urandom};
        seq++;
        cmd_v_i    = 1'b1;
        @(negedge clk);
        chk("full_ready", 128'(cmd_ready_and_o), 128'd0);
        chk("full_cmd_v", 128'(cmd_v_o), 128'd0);
        resp_en   = 2'b11;
        first_pop = -1;
        acc_cyc   = -1;
        n         = 0;
        while (acc_cyc < 0 && n < 50) begin
            @(negedge clk);
            if (first_pop < 0 && resp_v_o && resp_ready_and_i) first_pop = n;
            if (cmd_ready_and_o) acc_cyc = n;
            n++;
        end
        @(posedge clk); #1;
        cmd_v_i = 1'b0;
        chk("accept_after_pop", 128'(acc_cyc), 128'(first_pop + 1));
        wait_drain();

        // Simultaneous push and pop at count 4.
        resp_en = 2'b00;
        for (int i = 0; i < 4; i++) send(40'($urandom), vo);
        @(negedge clk);
        chk("outstanding_4", 128'(outstanding_o), 128'd4);
        @(posedge clk); #1;
        resp_en    = 2'b11;
        cmd_addr_i = 40'($urandom);
        cmd_i      = {32'(seq), $urandom, $urandom, $urandom};
        seq++;
        cmd_v_i    = 1'b1;
        @(negedge clk);
        chk("push_pop_both", 128'(cmd_ready_and_o && resp_v_o && resp_ready_and_i), 128'd1);
        @(posedge clk); #1;
        cmd_v_i = 1'b0;
        @(negedge clk);
        chk("push_pop_count", 128'(outstanding_o), 128'd4);
        wait_drain();

        // Randomized traffic, long enough to wrap the order pointers.
        rand_mode = 1'b1;
        for (int i = 0; i < 40; i++) send(40'($urandom), vo);
        rand_mode       = 1'b0;
        cmd_ready_and_i = 2'b11;
        wait_drain();

        // Reset with 3 in flight; stale channel responses must be ignored.
        resp_en = 2'b00;
        send(40'h000, vo);
        send(40'h040, vo);
        send(40'h080, vo);
        reset_i = 1'b1;
        @(posedge clk); #1;
        reset_i = 1'b0;
        resp_en = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_reset_cnt", 128'(outstanding_o), 128'd0);
            chk("post_reset_resp_v", 128'(resp_v_o), 128'd0);
            chk("post_reset_resp_ready", 128'(resp_ready_and_o), 128'd0);
        end
        @(posedge clk); #1;
        flush_gen++;
        repeat (2) @(posedge clk);
        #1;
        send(40'h040, vo);
        chk("recover_stripe", 128'(vo), 128'd2);
        wait_drain();

        // Hashed four-channel selection.
        haddrs[0] = 40'h1C0;
        haddrs[1] = 40'h040;
        haddrs[2] = 40'h100;
        haddrs[3] = 40'h0C0;
        haddrs[4] = 40'($urandom);
        for (int i = 0; i < 5; i++) begin
            h_addr = haddrs[i];
            #1;
            chk("hash_sel", 128'(h_cmd_v_o),
                128'(4'b0001 << (((haddrs[i] >> 6) ^ (haddrs[i] >> 8)) & 40'd3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bsg_bp_mem_channel_striper.md
BSG_BP_MEM_CHANNEL_STRIPER -- requirements
Module: bsg_bp_mem_channel_striper

Interface
REQ-001 Parameter num_chan_p, default 2: number of downstream memory channels; power of 2, range 1..8.
REQ-002 Parameter cmd_width_p, default 128: width of the opaque command message in bits.
REQ-003 Parameter resp_width_p, default 128: width of the opaque response message in bits.
REQ-004 Parameter addr_width_p, default 40: width of the command address.
REQ-005 Parameter stripe_lsb_p, default 6: lowest address bit of the channel-select field (block offset).
REQ-006 Parameter hash_en_p, default 0: when 1, selects XOR-folded channel hashing.
REQ-007 Parameter max_outstanding_p, default 8: order-FIFO depth; power of 2, at least 2.
REQ-008 Port clk_i, input, 1 bit: the single clock.
REQ-009 Port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-010 Port cmd_i, input, cmd_width_p bits: upstream command message.
REQ-011 Port cmd_addr_i, input, addr_width_p bits: address of cmd_i.
REQ-012 Port cmd_v_i, input, 1 bit: upstream command valid.
REQ-013 Port cmd_ready_and_o, output, 1 bit: upstream command ready.
REQ-014 Port cmd_o, output, [num_chan_p][cmd_width_p] bits: per-channel commands.
REQ-015 Port cmd_v_o, output, num_chan_p bits: per-channel command valids.
REQ-016 Port cmd_ready_and_i, input, num_chan_p bits: per-channel command readies.
REQ-017 Port resp_i, input, [num_chan_p][resp_width_p] bits: per-channel responses.
REQ-018 Port resp_v_i, input, num_chan_p bits: per-channel response valids.
REQ-019 Port resp_ready_and_o, output, num_chan_p bits: per-channel response readies.
REQ-020 Port resp_o, output, resp_width_p bits: merged upstream response.
REQ-021 Port resp_v_o, output, 1 bit: merged response valid.
REQ-022 Port resp_ready_and_i, input, 1 bit: upstream response ready.
REQ-023 Port outstanding_o, output, clog2(max_outstanding_p+1) bits: count of in-flight commands.

Function
REQ-024 Channel selection:
- Let L = clog2(num_chan_p).
- Base: sel = cmd_addr_i[stripe_lsb_p +: L].
- With hash_en_p=1: sel = base XOR cmd_addr_i[stripe_lsb_p+L +: L].
- With num_chan_p=1: sel = 0.
REQ-025 Command path is combinational, zero latency:
- cmd_o[c] = cmd_i for every c.
- cmd_v_o[c] = cmd_v_i & (c==sel) & ~full.
REQ-026 cmd_ready_and_o = cmd_ready_and_i[sel] & ~full.
REQ-027 Command handshake (cmd_v_i & cmd_ready_and_o) pushes sel into the order FIFO at the clock edge.
REQ-028 full = (outstanding_o == max_outstanding_p); while full, no command is accepted, even if a pop occurs the same cycle.
REQ-029 Response path, with head = oldest FIFO entry:
- resp_o = resp_i[head].
- resp_v_o = resp_v_i[head] & ~empty.
REQ-030 resp_ready_and_o[c] = resp_ready_and_i & ~empty & (c==head); non-head channels are back-pressured, so responses return to upstream in command order.
REQ-031 Response handshake (resp_v_o & resp_ready_and_i) pops the FIFO head at the clock edge.
REQ-032 A response arriving while empty is ignored: resp_v_o=0 and ready=0.
REQ-033 Outstanding count on a simultaneous push and pop:
- outstanding_o unchanged.
- FIFO read and write pointers both advance.
- Pointers wrap modulo max_outstanding_p.
REQ-034 A push that would exceed max_outstanding_p, or a pop from empty, never occurs; these are asserted in simulation.
REQ-035 Outputs depend combinationally on inputs only through REQ-025/026/029/030; outstanding_o is registered.

Reset
REQ-036 While reset_i is high at a clock edge:
- FIFO empties, pointers go to 0, outstanding_o goes to 0.
- Commands are not accepted, so cmd_ready_and_o and cmd_v_o are 0 that cycle.
REQ-037 After reset, resp_v_o=0 and resp_ready_and_o=0 until the first push.
REQ-038 Reset mid-operation discards all in-flight order state; the environment must also reset the channels.

Verification
REQ-039 Scenario: num_chan_p=2, stripe_lsb_p=6; commands at addr 0x000, 0x040, 0x080 -> cmd_v_o one-hot on channels 0, 1, 0; outstanding_o reaches 3.
REQ-040 Scenario: channel 1 responds before channel 0 for the above -> resp_ready_and_o[1]=0 until channel 0's response pops; upstream order is ch0, ch1, ch0.
REQ-041 Scenario: max_outstanding_p=8; issue 8 commands with no responses -> cmd_ready_and_o=0 on the 9th; pop one -> 9th accepted the next cycle.
REQ-042 Scenario: simultaneous push and pop at count 4 -> count stays 4; pointer wrap over 20+ transactions keeps order.
REQ-043 Scenario: hash_en_p=1, num_chan_p=4, addr 0x1C0 -> base 3, fold 1, sel 2.
REQ-044 Scenario: reset_i asserted with 3 outstanding -> outstanding_o=0 and resp_v_o=0 the next cycle; a stale channel response is ignored.
